ram_bist_ctrl: RTL and testbench

- Built-in self-test initiator for the single-port synchronous RAM (d/o/addr/cs/rw interface, rw=0 write, rw=1 read).
- On start, runs a 4-element March test over the full address space, compares read data with the expected pattern, and reports pass/fail plus the first failing address and data.
- Sits between the system controller and the RAM and drives the RAM ports directly.

---
 rtl/ram_bist_pkg.sv | 36 +++
 rtl/bist_addr_gen.sv | 31 +++
 rtl/ram_bist_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared definitions for the March RAM BIST controller: FSM encoding, element
// indices and the per-element behaviour tables.
package ram_bist_pkg;

    localparam int         BIST_DW  = 8;
    localparam int         BIST_AW  = 4;
    localparam logic [7:0] BIST_PAT = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CHK  = 3'd3,
        ST_NXT  = 3'd4,
        ST_FIN  = 3'd5
    } state_e;

    typedef logic [1:0] elem_t;

    localparam elem_t M0 = 2'd0;
    localparam elem_t M1 = 2'd1;
    localparam elem_t M2 = 2'd2;
    localparam elem_t M3 = 2'd3;

    // Bit i of each table describes element Mi.
    localparam logic [3:0] ELEM_DOWN   = 4'b1100;
    localparam logic [3:0] ELEM_RD     = 4'b1110;
    localparam logic [3:0] ELEM_WR     = 4'b0111;
    localparam logic [3:0] ELEM_RD_INV = 4'b0100;
    localparam logic [3:0] ELEM_WR_INV = 4'b0010;

    function automatic state_e first_state(input elem_t e);
        return ELEM_RD[e] ? ST_RD : ST_WR;
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter for the BIST controller, with load, step and a flag
// marking the final address of the current sweep direction.
module bist_addr_gen #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          step_i,
    input  logic          down_i,
    input  logic [AW-1:0] load_val_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [AW-1:0] addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (load_i) begin
            addr_q <= load_val_i;
        end else if (step_i) begin
            addr_q <= down_i ? (addr_q - AW'(1)) : (addr_q + AW'(1));
        end
    end

    assign addr_o = addr_q;
    assign last_o = down_i ? (addr_q == '0) : (addr_q == {AW{1'b1}});

endmodule

// File: rtl/ram_bist_ctrl.sv
// March BIST initiator driving a single-port synchronous RAM directly.
// Optional macro BIST_STOP_ON_FAIL_EN ends the test at the first mismatch.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int            DW  = BIST_DW,
    parameter int            AW  = BIST_AW,
    parameter logic [DW-1:0] PAT = DW'(BIST_PAT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic [DW-1:0] d,
    output logic [AW-1:0] addr,
    output logic          cs,
    output logic          rw,
    input  logic [DW-1:0] o
);

    state_e        state_q;
    elem_t         elem_q;
    logic          busy_q, done_q, pass_q, cs_q, rw_q;
    logic [AW-1:0] fail_addr_q;
    logic [DW-1:0] fail_data_q, d_q;

    logic          addr_last, ag_load, ag_step;
    logic [AW-1:0] ag_load_val;
    logic [DW-1:0] exp_data, wr_data, acc_wdata;
    logic          mismatch, stop_now, adv, elem_end, fin_now, issue;
    elem_t         elem_nxt, acc_elem;

    assign elem_nxt = elem_q + 2'd1;
    assign exp_data = ELEM_RD_INV[elem_q] ? ~PAT : PAT;
    assign wr_data  = ELEM_WR_INV[elem_q] ? ~PAT : PAT;
    assign mismatch = (state_q == ST_CHK) && (o != exp_data);

`ifdef BIST_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    // adv marks the last cycle spent on the current address.
    assign adv      = (state_q == ST_WR) ||
                      ((state_q == ST_CHK) && !stop_now && !ELEM_WR[elem_q]);
    assign elem_end = adv && addr_last;
    assign fin_now  = stop_now || (elem_end && (elem_q == M3));
    assign issue    = ((state_q == ST_IDLE) && start) || (adv && !fin_now);

    always_comb begin
        acc_elem = elem_q;
        if (state_q == ST_IDLE) begin
            acc_elem = M0;
        end else if (elem_end) begin
            acc_elem = elem_nxt;
        end
        acc_wdata = ELEM_WR_INV[acc_elem] ? ~PAT : PAT;
    end

    // A new element reloads the counter with its own starting corner.
    always_comb begin
        ag_load     = 1'b0;
        ag_step     = 1'b0;
        ag_load_val = '0;
        if (issue && (state_q == ST_IDLE || elem_end)) begin
            ag_load     = 1'b1;
            ag_load_val = ELEM_DOWN[acc_elem] ? {AW{1'b1}} : '0;
        end else if (adv && !addr_last) begin
            ag_step = 1'b1;
        end
    end

    bist_addr_gen #(.AW(AW)) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ag_load),
        .step_i     (ag_step),
        .down_i     (ELEM_DOWN[elem_q]),
        .load_val_i (ag_load_val),
        .addr_o     (addr),
        .last_o     (addr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            elem_q      <= M0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            d_q         <= '0;
            cs_q        <= 1'b0;
            rw_q        <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        pass_q <= 1'b1;
                    end
                end
                ST_RD: begin
                    state_q <= ST_CHK;
                    cs_q    <= 1'b0;
                    rw_q    <= 1'b1;
                end
                ST_CHK: begin
                    if (mismatch && pass_q) begin
                        pass_q      <= 1'b0;
                        fail_addr_q <= addr;
                        fail_data_q <= o;
                    end
                    if (!stop_now && ELEM_WR[elem_q]) begin
                        state_q <= ST_WR;
                        cs_q    <= 1'b1;
                        rw_q    <= 1'b0;
                        d_q     <= wr_data;
                    end
                end
                ST_WR: begin
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cs_q    <= 1'b0;
                    rw_q    <= 1'b1;
                end
            endcase

            if (issue) begin
                elem_q  <= acc_elem;
                state_q <= first_state(acc_elem);
                cs_q    <= 1'b1;
                rw_q    <= ELEM_RD[acc_elem];
                if (!ELEM_RD[acc_elem]) begin
                    d_q <= acc_wdata;
                end
            end

            if (fin_now) begin
                state_q <= ST_FIN;
                cs_q    <= 1'b0;
                rw_q    <= 1'b1;
                done_q  <= 1'b1;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign d         = d_q;
    assign cs        = cs_q;
    assign rw        = rw_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: scenario table, random stuck-bit faults checked
// against a March-level model, plus reset and start-while-busy sequences.
`timescale 1ns/1ps
module tb_ram_bist_ctrl;

    localparam int         DW  = 8;
    localparam int         AW  = 4;
    localparam int         N   = 16;
    localparam logic [7:0] PAT = 8'h55;
`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pass, cs, rw;
    logic [AW-1:0] fail_addr, addr;
    logic [DW-1:0] fail_data, d;
    logic [DW-1:0] o = '0;

    ram_bist_ctrl #(.DW(DW), .AW(AW), .PAT(PAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .d         (d),
        .addr      (addr),
        .cs        (cs),
        .rw        (rw),
        .o         (o)
    );

    always #5 clk = ~clk;

    // RAM model; the optional stuck bit shows up on the read path.
    logic [DW-1:0] mem [N];
    logic          f_en = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_mask = '0;
    logic          f_val = 1'b0;
    int            wr_count = 0;

    function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
        if (f_en && a == f_addr) return f_val ? (v | f_mask) : (v & ~f_mask);
        return v;
    endfunction

    always @(posedge clk) begin
        if (cs) begin
            if (!rw) begin
                mem[addr] <= d;
                wr_count  <= wr_count + 1;
            end else begin
                o <= faulty(addr, mem[addr]);
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: walk the March elements directly.
    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] data;
        int            cyc;
    } acc_t;

    acc_t          exp_q[$];
    bit            m_pass;
    logic [AW-1:0] m_fa;
    logic [DW-1:0] m_fd;
    int            m_done;

    task automatic model_run();
        logic [DW-1:0] mm [N];
        logic [DW-1:0] rexp, wdat, rv;
        logic [AW-1:0] a;
        bit has_rd, has_wr, dn, stopped;
        int cyc;
        acc_t ac;
        exp_q.delete();
        m_pass = 1'b1; m_fa = '0; m_fd = '0;
        cyc = 0; stopped = 1'b0;
        for (int e = 0; e < 4 && !stopped; e++) begin
            has_rd = (e != 0);
            has_wr = (e != 3);
            dn     = (e >= 2);
            rexp   = (e == 2) ? ~PAT : PAT;
            wdat   = (e == 1) ? ~PAT : PAT;
            for (int i = 0; i < N && !stopped; i++) begin
                a = dn ? AW'(N - 1 - i) : AW'(i);
                if (has_rd) begin
                    ac.wr = 1'b0; ac.a = a; ac.data = '0; ac.cyc = cyc + 1;
                    exp_q.push_back(ac);
                    cyc += 2;
                    rv = faulty(a, mm[a]);
                    if (rv !== rexp) begin
                        if (m_pass) begin m_pass = 1'b0; m_fa = a; m_fd = rv; end
                        if (STOP) stopped = 1'b1;
                    end
                end
                if (has_wr && !stopped) begin
                    ac.wr = 1'b1; ac.a = a; ac.data = wdat; ac.cyc = cyc + 1;
                    exp_q.push_back(ac);
                    mm[a] = wdat;
                    cyc += 1;
                end
            end
        end
        m_done = cyc + 1;
    endtask

    // One test run; cycle c is the c-th cycle after the start edge.
    task automatic run_bist(input bit glitch, input string tag,
                            output int done_at, output int n_done, output int busy_cnt);
        acc_t ex;
        done_at = 0; n_done = 0; busy_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c > 1) @(negedge clk);
            start = glitch && (c == 10 || c == 144 || c == 145);
            if (busy) busy_cnt++;
            if (c == 1) check({tag, " pass preset"}, 32'(pass), 32'(1));
            if (done) begin
                n_done++;
                if (done_at == 0) done_at = c;
            end
            if (!rw && !cs) check({tag, " rw0 without cs"}, 32'(c), 32'(0));
            if (cs && (done || !busy)) check({tag, " cs outside test"}, 32'(c), 32'(0));
            if (cs) begin
                if (exp_q.size() == 0) begin
                    check({tag, " unexpected access"}, 32'(c), 32'(0));
                end else begin
                    ex = exp_q.pop_front();
                    check($sformatf("%s acc cyc a=%0h", tag, ex.a), 32'(c), 32'(ex.cyc));
                    check($sformatf("%s acc op c=%0d", tag, c), 32'(!rw), 32'(ex.wr));
                    check($sformatf("%s acc addr c=%0d", tag, c), 32'(addr), 32'(ex.a));
                    if (ex.wr) check($sformatf("%s acc data c=%0d", tag, c), 32'(d), 32'(ex.data));
                end
            end
            if (done_at != 0 && c >= done_at + 4) break;
        end
        if (done_at == 0) check({tag, " done timeout"}, 32'(0), 32'(1));
        check({tag, " missing accesses"}, 32'(exp_q.size()), 32'(0));
        check({tag, " done count"}, 32'(n_done), 32'(1));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(done_at));
    endtask

    typedef struct {
        bit            f_en;
        logic [AW-1:0] f_addr;
        logic [DW-1:0] f_mask;
        bit            f_val;
        bit            glitch;
        bit            exp_pass;
        logic [AW-1:0] exp_fa;
        logic [DW-1:0] exp_fd;
        int            exp_done;
    } scen_t;

    scen_t tab[6];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at, n_done, busy_cnt, wcnt;
        tab[0] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 145};
        tab[1] = '{1'b1, 4'h3, 8'h01, 1'b1, 1'b0, 1'b0, 4'h3, 8'hAB, STOP ? 103 : 145};
        tab[2] = '{1'b1, 4'h3, 8'h01, 1'b0, 1'b0, 1'b0, 4'h3, 8'h54, STOP ? 28 : 145};
        tab[3] = '{1'b1, 4'h0, 8'h80, 1'b1, 1'b0, 1'b0, 4'h0, 8'hD5, STOP ? 19 : 145};
        tab[4] = '{1'b1, 4'hF, 8'h02, 1'b0, 1'b0, 1'b0, 4'hF, 8'hA8, STOP ? 67 : 145};
        tab[5] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 145};
        for (int i = 0; i < N; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'(0));
        check("reset done", 32'(done), 32'(0));
        check("reset pass", 32'(pass), 32'(0));
        check("reset fail_addr", 32'(fail_addr), 32'(0));
        check("reset fail_data", 32'(fail_data), 32'(0));
        check("reset d", 32'(d), 32'(0));
        check("reset addr", 32'(addr), 32'(0));
        check("reset cs", 32'(cs), 32'(0));
        check("reset rw", 32'(rw), 32'(1));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            f_en = tab[i].f_en; f_addr = tab[i].f_addr;
            f_mask = tab[i].f_mask; f_val = tab[i].f_val;
            model_run();
            run_bist(tab[i].glitch, $sformatf("case%0d", i), done_at, n_done, busy_cnt);
            check($sformatf("case%0d done cycle", i), 32'(done_at), 32'(tab[i].exp_done));
            check($sformatf("case%0d pass", i), 32'(pass), 32'(tab[i].exp_pass));
            if (!tab[i].exp_pass) begin
                check($sformatf("case%0d fail_addr", i), 32'(fail_addr), 32'(tab[i].exp_fa));
                check($sformatf("case%0d fail_data", i), 32'(fail_data), 32'(tab[i].exp_fd));
            end
            $display("case%0d: fault=%0b done@%0d pass=%0b fail_addr=%0h fail_data=%0h",
                     i, tab[i].f_en, done_at, pass, fail_addr, fail_data);
        end
        for (int i = 0; i < N; i++) check($sformatf("final mem[%0d]", i), 32'(mem[i]), 32'(PAT));

        // Reset asserted between edges in the middle of a run.
        f_en = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (49) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset cs", 32'(cs), 32'(0));
        check("midreset busy", 32'(busy), 32'(0));
        check("midreset pass", 32'(pass), 32'(0));
        check("midreset rw", 32'(rw), 32'(1));
        wcnt = wr_count;
        repeat (3) @(negedge clk);
        check("midreset no writes", 32'(wr_count), 32'(wcnt));
        rst_n = 1'b1;
        @(negedge clk);
        model_run();
        run_bist(1'b0, "after_reset", done_at, n_done, busy_cnt);
        check("after_reset done cycle", 32'(done_at), 32'(145));
        check("after_reset pass", 32'(pass), 32'(1));
        $display("after_reset: done@%0d pass=%0b", done_at, pass);

        // Random single stuck-bit faults against the model.
        for (int r = 0; r < 6; r++) begin
            f_en   = 1'($urandom_range(0, 1));
            f_addr = AW'($urandom_range(0, N - 1));
            f_mask = DW'(1 << $urandom_range(0, DW - 1));
            f_val  = 1'($urandom_range(0, 1));
            model_run();
            run_bist(1'b0, $sformatf("rand%0d", r), done_at, n_done, busy_cnt);
            check($sformatf("rand%0d done cycle", r), 32'(done_at), 32'(m_done));
            check($sformatf("rand%0d pass", r), 32'(pass), 32'(m_pass));
            if (!m_pass) begin
                check($sformatf("rand%0d fail_addr", r), 32'(fail_addr), 32'(m_fa));
                check($sformatf("rand%0d fail_data", r), 32'(fail_data), 32'(m_fd));
            end
            $display("rand%0d: fault=%0b a=%0h mask=%0h sa=%0b done@%0d pass=%0b",
                     r, f_en, f_addr, f_mask, f_val, done_at, pass);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
